// File: rtl/mips32_mem_pkg.sv
// Shared constants, FSM state type and request record for the MIPS32 memory responder.
// Latency: none (declarations only).
// Backpressure: n/a.
package mips32_mem_pkg;

  localparam int WORD_W            = 32;
  localparam int ADDR_W            = 32;
  localparam int MEM_DEPTH_DEFAULT = 1024;
  localparam int WAIT_W            = 4;
  localparam int PERF_W            = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // One captured initiator request.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Full-width range test: high address bits never alias onto the array.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int depth);
    return addr < ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/mips32_mem_array.sv
// Single-port synchronous 1RW word store, DEPTH x 32, read-before-write.
// Latency: rdata valid one edge after an enabled access; holds until the next access.
// Backpressure: none; caller enables exactly when an access is wanted.
module mips32_mem_array
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are never reset; rdata captures the old word even on a write.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) begin
        mem[addr] <= wdata;
      end
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory responder: one outstanding LW/IF/SW request, WAIT_CYCLES wait states, range-checked array access.
// Latency: rsp_valid in the (WAIT_CYCLES+1)-th cycle after the accept edge; optional perf counters via MIPS32_MEM_RSP_PERF_EN.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready is sampled high.
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int DEPTH       = MEM_DEPTH_DEFAULT,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef MIPS32_MEM_RSP_PERF_EN
  ,
  output logic [PERF_W-1:0] rd_count,
  output logic [PERF_W-1:0] wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  mem_req_t          req_q;
  mem_req_t          req_live;
  mem_req_t          acc;
  logic              hs;
  logic              enter_resp;
  logic              acc_in_range;
  logic              q_in_range;
  logic              arr_en;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state_q == ST_IDLE);
  assign hs        = req_valid && req_ready;
  assign req_live  = '{we: req_we, addr: req_addr, wdata: req_wdata};

  // Next state and wait counter; enter_resp marks the single array-access edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and captured request; reset drops any request not yet committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        req_q <= req_live;
      end
    end
  end

  // With zero wait states the access happens on the accept edge itself, so
  // the array must see the live bus rather than the not-yet-captured copy.
  assign acc          = (state_q == ST_IDLE) ? req_live : req_q;
  assign acc_in_range = addr_in_range(acc.addr, DEPTH);
  assign arr_en       = enter_resp && acc_in_range;
  assign q_in_range   = addr_in_range(req_q.addr, DEPTH);

  mips32_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (acc.we),
    .addr  (acc.addr[AW-1:0]),
    .wdata (acc.wdata),
    .rdata (arr_rdata)
  );

  // Response is a pure function of state and the captured request, so it is
  // stable for as long as RESP lasts and zero everywhere else.
  always_comb begin
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    if (state_q == ST_RESP) begin
      rsp_err = !q_in_range;
      if (!req_q.we && q_in_range) begin
        rsp_rdata = arr_rdata;
      end
    end
  end

`ifdef MIPS32_MEM_RSP_PERF_EN
  logic rsp_done;
  assign rsp_done = (state_q == ST_RESP) && rsp_ready && q_in_range;

  // Saturating counts of completed in-range loads and stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (rsp_done) begin
      if (req_q.we) begin
        if (wr_count != {PERF_W{1'b1}}) wr_count <= wr_count + 1'b1;
      end else begin
        if (rd_count != {PERF_W{1'b1}}) rd_count <= rd_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/mips32_mem_responder.md
MIPS32_MEM_RESPONDER -- requirements
Module: mips32_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, words of storage (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between accept and response (0..15).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (SW), 0 = load/fetch (LW/IF).
REQ-008 req_addr  input  32  word address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator accepts response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  address out of range (req_addr >= DEPTH).

Function
REQ-014 FSM states IDLE, WAIT, RESP; exactly one request outstanding at a time.
REQ-015 req_ready shall be 1 only in IDLE; handshake = req_valid && req_ready on a rising edge.
REQ-016 On handshake, req_we, req_addr, req_wdata shall be latched; later changes on req_* shall be ignored.
REQ-017 IDLE->WAIT on handshake when WAIT_CYCLES>0, wait counter loaded with WAIT_CYCLES-1.
REQ-018 WAIT decrements each cycle; WAIT->RESP on the cycle the counter is 0.
REQ-019 IDLE->RESP directly on handshake when WAIT_CYCLES==0.
REQ-020 Latency: rsp_valid asserts WAIT_CYCLES+1 cycles after the handshake edge.
REQ-021 Array access (read or write) shall occur exactly once, on the edge entering RESP.
REQ-022 Store: array[addr] <= wdata; rsp_rdata=0. Load: rsp_rdata = array[addr] contents before any write in that edge.
REQ-023 Out-of-range address: no array write, rsp_rdata=0, rsp_err=1; otherwise rsp_err=0.
REQ-024 rsp_valid, rsp_rdata, rsp_err shall remain stable in RESP until rsp_ready is sampled 1.
REQ-025 RESP->IDLE when rsp_ready=1; rsp_valid deasserts next cycle; a new request cannot be accepted in the same cycle (req_ready=0 in RESP).
REQ-026 Address comparison uses full 32 bits; no wrap-around or aliasing of high bits.

Reset
REQ-027 rst_n=0 forces state IDLE, wait counter 0, req_ready=1 after reset release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 Array contents shall not be reset.
REQ-029 Reset during WAIT shall drop the request; a store not yet committed shall not modify the array.

Configuration
REQ-030 Macro MIPS32_MEM_RSP_PERF_EN: when defined, add outputs rd_count (16) and wr_count (16), incremented on each completed in-range load/store response handshake, saturating at 16'hFFFF, reset to 0.
REQ-031 Without MIPS32_MEM_RSP_PERF_EN the ports and counters shall not exist; all other behaviour identical.

Structure
REQ-032 Package mips32_mem_pkg shall hold the FSM state enum typedef, default DEPTH, and the word/address width constants shared with the pipelined CPU.
REQ-033 Storage shall be a sub-module mips32_mem_array: single-port synchronous 1RW, DEPTH x 32, read-before-write.

Verification
REQ-034 WAIT_CYCLES=2: store addr 5 data 32'hDEAD_BEEF, then load addr 5 -> rsp_valid 3 cycles after each handshake, load rdata 32'hDEAD_BEEF, err 0.
REQ-035 WAIT_CYCLES=0: load addr 0 after storing 32'h0000_0014 -> rsp_valid 1 cycle after handshake, rdata 32'h14.
REQ-036 Load addr 1024 and store addr 32'h8000_0005 -> rsp_err=1, rdata=0, array addr 5 unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP, toggle req_* -> rsp outputs stable, req_ready=0, no second access.
REQ-038 Assert rst_n=0 during WAIT of a store to addr 7 (prior value 32'h1) -> outputs reset values; later load addr 7 returns 32'h1.
REQ-039 With MIPS32_MEM_RSP_PERF_EN: 3 loads, 2 stores, 1 out-of-range load -> rd_count=3, wr_count=2.
